io_capture: RTL

- Synthesizable monitor/receiver counterpart to the IO driver VIP.
- Samples a WIDTH-bit asynchronous IO bus and detects value changes.
- Records each change as a {timestamp, value} event in an internal FIFO, drained through a valid/ready stream.
- Sits between a DUT's IO pins and a test/debug consumer (DMA or bench), giving a cycle-accurate trace of the bus.

---
 rtl/io_capture_pkg.sv | 23 ++
 rtl/io_capture_if.sv | 24 ++
 rtl/io_capture_fifo.sv | 70 +++++++
 rtl/io_capture.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/io_capture_pkg.sv
// Shared types and helpers for the IO capture monitor.
// Event layout is {timestamp, value} with the value in the LSBs.
package io_capture_pkg;

  localparam int DROP_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Packed event width for a given timestamp/value split.
  function automatic int event_width(input int ts_width, input int value_width);
    return ts_width + value_width;
  endfunction

  // Saturating increment used by the drop counter.
  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + DROP_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/io_capture_if.sv
// Event stream from the capture block to its consumer: valid/ready with
// {timestamp, value} payload; data holds while valid is high and ready is low.
interface io_capture_if #(
  parameter int WIDTH    = 1,
  parameter int TS_WIDTH = 32
);

  logic                      out_valid;
  logic                      out_ready;
  logic [TS_WIDTH+WIDTH-1:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/io_capture_fifo.sv
// Sync FIFO, registered first-word-fall-through output; write-to-valid is 2 edges.
// Full FIFO refuses pushes unless the head pops in the same cycle; no bypass path.
module io_capture_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_accept,
  output logic                  full,
  output logic                  empty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   mem_cnt;
  logic [ADDR_WIDTH:0]   occupancy;
  logic                  pop;
  logic                  load;

  // Occupancy counts the output register too, so capacity is exactly DEPTH.
  assign occupancy   = mem_cnt + {{ADDR_WIDTH{1'b0}}, out_valid};
  assign full        = (occupancy == DEPTH_CNT);
  assign empty       = (occupancy == '0);
  assign pop         = out_valid && out_ready;
  assign push_accept = push && (!full || pop);
  assign load        = (mem_cnt != '0) && (!out_valid || pop);

  always_ff @(posedge clk) begin
    if (push_accept) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (push_accept) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (load) begin
        rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
        out_data  <= mem[rd_ptr];
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      case ({push_accept, load})
        2'b10:   mem_cnt <= mem_cnt + (ADDR_WIDTH+1)'(1);
        2'b01:   mem_cnt <= mem_cnt - (ADDR_WIDTH+1)'(1);
        default: mem_cnt <= mem_cnt;
      endcase
    end
  end

endmodule

// File: rtl/io_capture.sv
// Samples an async bus, timestamps every value change and queues it as an event.
// Change-to-out_valid is SYNC_STAGES+2 edges; events arriving at a full queue are dropped and counted.
module io_capture
  import io_capture_pkg::*;
#(
  parameter int WIDTH           = 1,
  parameter int TS_WIDTH        = 32,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [WIDTH-1:0]          in,
  io_capture_if.master              stream,
  output logic                      overflow,
  input  logic                      clear_overflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam int EVENT_WIDTH = event_width(TS_WIDTH, WIDTH);

  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [WIDTH-1:0]    value;
  } event_t;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  in_s;
  state_t                            state_q, state_d;
  logic [TS_WIDTH-1:0]               ts_q, ts_d;
  logic [WIDTH-1:0]                  prev_q, prev_d;
  logic                              evt_push;
  event_t                            evt;
  logic                              fifo_accept;
  logic                              fifo_full;
  logic                              fifo_empty;
  logic                              fifo_status_unused;
  logic                              drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end
  end

  assign in_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ts_q    <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      prev_q  <= prev_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ts_d      = ts_q;
    prev_d    = prev_q;
    evt_push  = 1'b0;
    evt.ts    = ts_q;
    evt.value = in_s;
    case (state_q)
      IDLE: begin
        ts_d = '0;
        if (enable) begin
          state_d = ARM;
        end
      end
      // The baseline event goes out even if enable has already dropped.
      ARM: begin
        evt_push = 1'b1;
        prev_d   = in_s;
        ts_d     = enable ? TS_WIDTH'(1) : '0;
        state_d  = enable ? RUN : IDLE;
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          ts_d    = '0;
        end else begin
          ts_d = ts_q + TS_WIDTH'(1);
          if (in_s != prev_q) begin
            evt_push = 1'b1;
            prev_d   = in_s;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  io_capture_fifo #(
    .DATA_WIDTH (EVENT_WIDTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (evt_push),
    .push_data   (evt),
    .push_accept (fifo_accept),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .out_valid   (stream.out_valid),
    .out_ready   (stream.out_ready),
    .out_data    (stream.out_data)
  );

  assign fifo_status_unused = fifo_full | fifo_empty;
  assign drop               = evt_push && !fifo_accept;

  // A same-cycle drop keeps overflow set, but the clear still zeroes the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
      if (clear_overflow) begin
        drop_count <= '0;
      end else if (drop) begin
        drop_count <= sat_inc(drop_count);
      end
    end
  end

endmodule
